// File: rtl/video_adapter_pkg.sv
// video_adapter_pkg: shared types, widths and colour expansion for the video output adapter.
// Latency: n/a (package).
// Backpressure: n/a (package).
package video_adapter_pkg;

    // Width of the measured geometry counters (pixels per line, lines per frame)
    localparam int GEOM_W  = 12;
    localparam int FRAME_W = 16;

    // Stats FSM: IDLE until the first VS so a partial frame after reset is never reported
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } stats_state_t;

    // Widen a 'bits'-wide channel (held in the LSBs of c) to 8 bits.
    // replicate=1 repeats the channel MSB-first until 8 bits are filled;
    // replicate=0 left-justifies it and zero-pads the LSBs.
    function automatic logic [7:0] expand_color(
        input logic [7:0] c,
        input int         bits,
        input logic       replicate
    );
        logic [7:0] w_out;
        w_out = '0;
        if (replicate) begin
            for (int i = 0; i < 8; i++) begin
                w_out[7 - i] = c[bits - 1 - (i % bits)];
            end
        end else begin
            w_out = c << (8 - bits);
        end
        return w_out;
    endfunction

endpackage

// File: rtl/sync_pulse_gen.sv
// sync_pulse_gen: pixel-enable-gated rising-edge detector for one sync line, polarity corrected.
// Latency: o_edge is combinational on the sampling cycle; the caller registers it into a 1-clk pulse.
// Backpressure: none; sync history only advances when i_ce is high and holds otherwise.
module sync_pulse_gen #(
    parameter bit ACTIVE_HIGH = 1'b1
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_ce,
    input  logic i_sync,
    output logic o_edge
);

    logic w_sync;
    logic r_prev;
    logic r_primed;

    // Internally the sync is always treated as active-high
    assign w_sync = ACTIVE_HIGH ? i_sync : ~i_sync;

    // The first sample after reset only loads history, so a sync that is
    // already active when reset releases does not produce a pulse.
    assign o_edge = i_ce & r_primed & w_sync & ~r_prev;

    // Sync history, advanced only on sampled pixels
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_prev   <= 1'b0;
            r_primed <= 1'b0;
        end else if (i_ce) begin
            r_prev   <= w_sync;
            r_primed <= 1'b1;
        end
    end

endmodule

// File: rtl/video_out_adapter.sv
// video_out_adapter: native core video (RGB/blank/sync/ce) to 24-bit video_if, optional frame geometry stats.
// Latency: 1 clk from the edge that samples ce_pixel=1 to DE/RGB/HS/VS; stats update on the VS pulse edge.
// Backpressure: none; video_if cannot stall, samples hold between pixel enables and vid_skip marks repeats.
// Build option: define VIDEO_ADAPTER_STATS_EN to build the geometry/frame counters, otherwise they read 0.
module video_out_adapter
    import video_adapter_pkg::*;
#(
    parameter int COLOR_BITS = 4,
    parameter int EXPAND     = 1,
    parameter int SYNC_POS   = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ce_pixel,
    input  logic [COLOR_BITS-1:0] r_in,
    input  logic [COLOR_BITS-1:0] g_in,
    input  logic [COLOR_BITS-1:0] b_in,
    input  logic                  hblank,
    input  logic                  vblank,
    input  logic                  hsync,
    input  logic                  vsync,
    output logic [23:0]           vid_rgb,
    output logic                  vid_de,
    output logic                  vid_hs,
    output logic                  vid_vs,
    output logic                  vid_skip,
    output logic [GEOM_W-1:0]     active_width,
    output logic [GEOM_W-1:0]     active_height,
    output logic [FRAME_W-1:0]    frame_count,
    output logic                  stats_valid
);

    logic        w_de_in;
    logic        w_de_next;
    logic [23:0] w_rgb_in;
    logic        w_hs_edge;
    logic        w_vs_edge;

    logic        r_de;
    logic [23:0] r_rgb;
    logic        r_hs;
    logic        r_vs;
    logic        r_ld1;
    logic        r_skip;

    assign w_de_in  = ~(hblank | vblank);
    assign w_rgb_in = {expand_color(8'(r_in), COLOR_BITS, EXPAND != 0),
                       expand_color(8'(g_in), COLOR_BITS, EXPAND != 0),
                       expand_color(8'(b_in), COLOR_BITS, EXPAND != 0)};

    // DE value the sample register will hold after this edge
    assign w_de_next = ce_pixel ? w_de_in : r_de;

    sync_pulse_gen #(
        .ACTIVE_HIGH(SYNC_POS != 0)
    ) u_hs_gen (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .i_ce      (ce_pixel),
        .i_sync    (hsync),
        .o_edge    (w_hs_edge)
    );

    sync_pulse_gen #(
        .ACTIVE_HIGH(SYNC_POS != 0)
    ) u_vs_gen (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .i_ce      (ce_pixel),
        .i_sync    (vsync),
        .o_edge    (w_vs_edge)
    );

    // Pixel sample registers: load on ce_pixel, hold between enables; RGB forced to 0 outside DE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_de  <= 1'b0;
            r_rgb <= '0;
        end else if (ce_pixel) begin
            r_de  <= w_de_in;
            r_rgb <= w_de_in ? w_rgb_in : 24'h0;
        end
    end

    // Single-clk sync pulses and skip flag: skip once the held sample is two or more clocks old
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hs   <= 1'b0;
            r_vs   <= 1'b0;
            r_ld1  <= 1'b0;
            r_skip <= 1'b0;
        end else begin
            r_hs   <= w_hs_edge;
            r_vs   <= w_vs_edge;
            r_ld1  <= ce_pixel;
            r_skip <= w_de_next & ~(ce_pixel | r_ld1);
        end
    end

    assign vid_rgb  = r_rgb;
    assign vid_de   = r_de;
    assign vid_hs   = r_hs;
    assign vid_vs   = r_vs;
    assign vid_skip = r_skip;

`ifdef VIDEO_ADAPTER_STATS_EN

    localparam logic [GEOM_W-1:0] GEOM_MAX = '1;

    stats_state_t        r_state;
    logic [GEOM_W-1:0]   r_pix_cnt;
    logic [GEOM_W-1:0]   r_line_cnt;
    logic [GEOM_W-1:0]   r_width;
    logic [GEOM_W-1:0]   r_height;
    logic [FRAME_W-1:0]  r_frames;
    logic                r_valid;

    logic                w_pix;
    logic                w_fall_de;
    logic [GEOM_W-1:0]   w_line_inc;

    assign w_pix      = ce_pixel & w_de_in;
    assign w_fall_de  = ce_pixel & r_de & ~w_de_in;
    assign w_line_inc = (r_line_cnt == GEOM_MAX) ? r_line_cnt : r_line_cnt + 12'd1;

    // Stats FSM and geometry counters; a DE fall coinciding with VS counts that line into the height
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_pix_cnt  <= '0;
            r_line_cnt <= '0;
            r_width    <= '0;
            r_height   <= '0;
            r_frames   <= '0;
            r_valid    <= 1'b0;
        end else begin
            if (w_pix && (r_pix_cnt != GEOM_MAX)) begin
                r_pix_cnt <= r_pix_cnt + 12'd1;
            end
            if (w_fall_de) begin
                r_width    <= r_pix_cnt;
                r_pix_cnt  <= '0;
                r_line_cnt <= w_line_inc;
            end
            if (w_vs_edge) begin
                r_frames   <= r_frames + 16'd1;
                r_line_cnt <= '0;
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_MEASURE;
                    end
                    ST_MEASURE: begin
                        r_height <= w_fall_de ? w_line_inc : r_line_cnt;
                        r_valid  <= 1'b1;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign active_width  = r_width;
    assign active_height = r_height;
    assign frame_count   = r_frames;
    assign stats_valid   = r_valid;

`else

    assign active_width  = '0;
    assign active_height = '0;
    assign frame_count   = '0;
    assign stats_valid   = 1'b0;

`endif

endmodule

// File: tb/tb_video_out_adapter.sv
// tb_video_out_adapter: directed checks of the video output adapter (RGB packing, DE, syncs, skip, stats).
// Latency: checks sample 1 time unit after the clock edge that registers the driven inputs.
// Backpressure: n/a (testbench).
module tb_video_out_adapter;

`ifdef VIDEO_ADAPTER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        ce_pixel;
    logic [3:0]  r4, g4, b4;
    logic [2:0]  r3, g3, b3;
    logic        hblank, vblank, hsync, vsync;

    logic [23:0] dut_rgb, pad_rgb, rep_rgb;
    logic        dut_de, dut_hs, dut_vs, dut_skip;
    logic        pad_de, pad_hs, pad_vs, pad_skip;
    logic        rep_de, rep_hs, rep_vs, rep_skip;
    logic [11:0] dut_w, dut_h, pad_w, pad_h, rep_w, rep_h;
    logic [15:0] dut_fc, pad_fc, rep_fc;
    logic        dut_sv, pad_sv, rep_sv;

    int checks   = 0;
    int failures = 0;

    video_out_adapter #(.COLOR_BITS(4), .EXPAND(1), .SYNC_POS(1)) u_dut (
        .clk(clk), .reset_n(reset_n), .ce_pixel(ce_pixel),
        .r_in(r4), .g_in(g4), .b_in(b4),
        .hblank(hblank), .vblank(vblank), .hsync(hsync), .vsync(vsync),
        .vid_rgb(dut_rgb), .vid_de(dut_de), .vid_hs(dut_hs), .vid_vs(dut_vs), .vid_skip(dut_skip),
        .active_width(dut_w), .active_height(dut_h), .frame_count(dut_fc), .stats_valid(dut_sv)
    );

    video_out_adapter #(.COLOR_BITS(3), .EXPAND(0), .SYNC_POS(0)) u_pad (
        .clk(clk), .reset_n(reset_n), .ce_pixel(ce_pixel),
        .r_in(r3), .g_in(g3), .b_in(b3),
        .hblank(hblank), .vblank(vblank), .hsync(hsync), .vsync(vsync),
        .vid_rgb(pad_rgb), .vid_de(pad_de), .vid_hs(pad_hs), .vid_vs(pad_vs), .vid_skip(pad_skip),
        .active_width(pad_w), .active_height(pad_h), .frame_count(pad_fc), .stats_valid(pad_sv)
    );

    video_out_adapter #(.COLOR_BITS(3), .EXPAND(1), .SYNC_POS(1)) u_rep (
        .clk(clk), .reset_n(reset_n), .ce_pixel(ce_pixel),
        .r_in(r3), .g_in(g3), .b_in(b3),
        .hblank(hblank), .vblank(vblank), .hsync(hsync), .vsync(vsync),
        .vid_rgb(rep_rgb), .vid_de(rep_de), .vid_hs(rep_hs), .vid_vs(rep_vs), .vid_skip(rep_skip),
        .active_width(rep_w), .active_height(rep_h), .frame_count(rep_fc), .stats_valid(rep_sv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; ce_pixel = 1'b1; hblank = 1'b0; vblank = 1'b0;
        hsync = 1'b1; vsync = 1'b0;
        r4 = 4'hA; g4 = 4'h5; b4 = 4'hF; r3 = 3'b101; g3 = 3'b011; b3 = 3'b111;
        tick(); tick();
        checks++; if (dut_rgb !== 24'h0) begin failures++; $display("FAIL reset_rgb got %h exp %h", dut_rgb, 24'h0); end
        checks++; if ({dut_de, dut_hs, dut_vs, dut_skip} !== 4'b0) begin failures++; $display("FAIL reset_flags got %b exp %b", {dut_de, dut_hs, dut_vs, dut_skip}, 4'b0); end
        checks++; if ({dut_w, dut_h, dut_fc, dut_sv} !== 41'h0) begin failures++; $display("FAIL reset_stats got %h exp %h", {dut_w, dut_h, dut_fc, dut_sv}, 41'h0); end
        reset_n = 1'b1;
        tick();
        checks++; if (dut_hs !== 1'b0) begin failures++; $display("FAIL active_sync_after_reset got %b exp %b", dut_hs, 1'b0); end
        checks++; if (dut_rgb !== 24'hAA55FF) begin failures++; $display("FAIL first_sample_rgb got %h exp %h", dut_rgb, 24'hAA55FF); end
        hsync = 1'b0;
        tick();
    endtask

    task automatic test_rgb();
        ce_pixel = 1'b1; hblank = 1'b0; vblank = 1'b0;
        r4 = 4'hA; g4 = 4'h5; b4 = 4'hF; r3 = 3'b101; g3 = 3'b011; b3 = 3'b111;
        tick();
        checks++; if (dut_rgb !== 24'hAA55FF) begin failures++; $display("FAIL rgb_expand4 got %h exp %h", dut_rgb, 24'hAA55FF); end
        checks++; if (pad_rgb !== 24'hA060E0) begin failures++; $display("FAIL rgb_pad3 got %h exp %h", pad_rgb, 24'hA060E0); end
        checks++; if (rep_rgb !== 24'hB66DFF) begin failures++; $display("FAIL rgb_rep3 got %h exp %h", rep_rgb, 24'hB66DFF); end
        checks++; if ({dut_de, dut_skip} !== 2'b10) begin failures++; $display("FAIL rgb_de_skip got %b exp %b", {dut_de, dut_skip}, 2'b10); end
        ce_pixel = 1'b0; r4 = 4'h1; g4 = 4'h2; b4 = 4'h3;
        tick();
        checks++; if ({dut_rgb, dut_skip} !== {24'hAA55FF, 1'b0}) begin failures++; $display("FAIL rgb_hold got %h exp %h", {dut_rgb, dut_skip}, {24'hAA55FF, 1'b0}); end
        ce_pixel = 1'b1;
        tick();
        checks++; if (dut_rgb !== 24'h112233) begin failures++; $display("FAIL rgb_second got %h exp %h", dut_rgb, 24'h112233); end
        ce_pixel = 1'b0;
        tick();
        checks++; if (dut_skip !== 1'b0) begin failures++; $display("FAIL skip_half_rate got %b exp %b", dut_skip, 1'b0); end
    endtask

    task automatic test_skip();
        logic exp_skip;
        hblank = 1'b0; vblank = 1'b0;
        for (int k = 0; k < 8; k++) begin
            ce_pixel = ((k % 4) == 0);
            tick();
            exp_skip = ((k % 4) >= 2);
            checks++; if (dut_skip !== exp_skip) begin failures++; $display("FAIL skip_quarter_%0d got %b exp %b", k, dut_skip, exp_skip); end
        end
        hblank = 1'b1; ce_pixel = 1'b1;
        tick();
        checks++; if ({dut_de, dut_rgb, dut_skip} !== 26'h0) begin failures++; $display("FAIL blank_outputs got %h exp %h", {dut_de, dut_rgb, dut_skip}, 26'h0); end
        ce_pixel = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if ({dut_rgb, dut_skip} !== 25'h0) begin failures++; $display("FAIL blank_hold_%0d got %h exp %h", k, {dut_rgb, dut_skip}, 25'h0); end
        end
    endtask

    task automatic test_sync();
        int dut_cnt;
        int pad_cnt;
        hsync = 1'b0; vsync = 1'b0; ce_pixel = 1'b1;
        tick(); tick();
        dut_cnt = 0; pad_cnt = 0;
        hsync = 1'b1;
        for (int i = 0; i < 40; i++) begin
            ce_pixel = ((i % 2) == 0);
            tick();
            dut_cnt += int'(dut_hs);
            pad_cnt += int'(pad_hs);
            if (i == 0) begin
                checks++; if (dut_hs !== 1'b1) begin failures++; $display("FAIL hs_first_clk got %b exp %b", dut_hs, 1'b1); end
            end
        end
        checks++; if (dut_cnt != 1) begin failures++; $display("FAIL hs_pulse_count got %0d exp %0d", dut_cnt, 1); end
        checks++; if (pad_cnt != 0) begin failures++; $display("FAIL hs_neg_on_rise got %0d exp %0d", pad_cnt, 0); end
        dut_cnt = 0; pad_cnt = 0;
        hsync = 1'b0;
        for (int j = 0; j < 6; j++) begin
            ce_pixel = ((j % 2) == 0);
            tick();
            dut_cnt += int'(dut_hs);
            pad_cnt += int'(pad_hs);
        end
        checks++; if (pad_cnt != 1) begin failures++; $display("FAIL hs_neg_fall_count got %0d exp %0d", pad_cnt, 1); end
        checks++; if (dut_cnt != 0) begin failures++; $display("FAIL hs_pos_fall_count got %0d exp %0d", dut_cnt, 0); end
        ce_pixel = 1'b1;
        tick();
        hsync = 1'b1; vsync = 1'b1;
        tick();
        checks++; if ({dut_hs, dut_vs} !== 2'b11) begin failures++; $display("FAIL hs_vs_together got %b exp %b", {dut_hs, dut_vs}, 2'b11); end
        tick();
        checks++; if ({dut_hs, dut_vs} !== 2'b00) begin failures++; $display("FAIL hs_vs_one_clk got %b exp %b", {dut_hs, dut_vs}, 2'b00); end
        hsync = 1'b0; vsync = 1'b0;
        tick();
    endtask

    task automatic test_stats();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1; ce_pixel = 1'b1; hblank = 1'b0; vblank = 1'b1; hsync = 1'b0; vsync = 1'b0;
        tick(); tick();
        vsync = 1'b1;
        tick();
        checks++; if ({dut_vs, dut_sv, dut_fc} !== {1'b1, 1'b0, (STATS ? 16'd1 : 16'd0)}) begin failures++; $display("FAIL stats_vs1 got %h exp %h", {dut_vs, dut_sv, dut_fc}, {1'b1, 1'b0, (STATS ? 16'd1 : 16'd0)}); end
        vsync = 1'b0; vblank = 1'b0;
        for (int l = 0; l < 224; l++) begin
            hblank = 1'b0;
            for (int p = 0; p < 304; p++) tick();
            hblank = 1'b1;
            tick();
        end
        hblank = 1'b0; vblank = 1'b1;
        tick(); tick();
        vsync = 1'b1;
        tick();
        checks++; if (dut_vs !== 1'b1) begin failures++; $display("FAIL stats_vs2_pulse got %b exp %b", dut_vs, 1'b1); end
        checks++; if (dut_sv !== STATS) begin failures++; $display("FAIL stats_valid got %b exp %b", dut_sv, STATS); end
        checks++; if (dut_w !== (STATS ? 12'd304 : 12'd0)) begin failures++; $display("FAIL stats_width got %0d exp %0d", dut_w, (STATS ? 304 : 0)); end
        checks++; if (dut_h !== (STATS ? 12'd224 : 12'd0)) begin failures++; $display("FAIL stats_height got %0d exp %0d", dut_h, (STATS ? 224 : 0)); end
        checks++; if (dut_fc !== (STATS ? 16'd2 : 16'd0)) begin failures++; $display("FAIL stats_frames got %0d exp %0d", dut_fc, (STATS ? 2 : 0)); end
        vsync = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        ce_pixel = 1'b1; hblank = 1'b0; vblank = 1'b0; hsync = 1'b0; vsync = 1'b0;
        r4 = 4'h7; g4 = 4'h8; b4 = 4'h9;
        tick(); tick(); tick();
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({dut_rgb, dut_de, dut_skip} !== 26'h0) begin failures++; $display("FAIL async_reset_video got %h exp %h", {dut_rgb, dut_de, dut_skip}, 26'h0); end
        checks++; if ({dut_w, dut_h, dut_fc, dut_sv} !== 41'h0) begin failures++; $display("FAIL async_reset_stats got %h exp %h", {dut_w, dut_h, dut_fc, dut_sv}, 41'h0); end
        @(negedge clk);
        reset_n = 1'b1; vblank = 1'b1;
        tick(); tick();
        vsync = 1'b1;
        tick();
        checks++; if ({dut_sv, dut_fc} !== {1'b0, (STATS ? 16'd1 : 16'd0)}) begin failures++; $display("FAIL restart_vs1 got %h exp %h", {dut_sv, dut_fc}, {1'b0, (STATS ? 16'd1 : 16'd0)}); end
        vsync = 1'b0; vblank = 1'b0;
        for (int p = 0; p < 5; p++) tick();
        hblank = 1'b1;
        tick();
        hblank = 1'b0;
        for (int p = 0; p < 5; p++) tick();
        vblank = 1'b1; vsync = 1'b1;
        tick();
        checks++; if (dut_sv !== STATS) begin failures++; $display("FAIL restart_valid got %b exp %b", dut_sv, STATS); end
        checks++; if ({dut_w, dut_h} !== (STATS ? {12'd5, 12'd2} : 24'h0)) begin failures++; $display("FAIL fall_de_with_vs got %h exp %h", {dut_w, dut_h}, (STATS ? {12'd5, 12'd2} : 24'h0)); end
        checks++; if (dut_fc !== (STATS ? 16'd2 : 16'd0)) begin failures++; $display("FAIL restart_frames got %0d exp %0d", dut_fc, (STATS ? 2 : 0)); end
        vsync = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_rgb();
        test_skip();
        test_sync();
        test_stats();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
